mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage. Sits directly downstream of the ID/EX control decode and the ALU.
//  Consumes the ALU result, store data and the active-low DmemREB/DmemWEB strobes.
//  Runs a req/ack transaction on a variable-latency data memory and stalls upstream while one is open.
//  Delivers a registered writeback record (rd, data, regwrite) to the WB stage.
// PARAMETERS
//  AW       32   data memory address width
//  DW       32   data width (word access only)
//  TIMEOUT  255  max BUSY cycles without MemAck before the access aborts (1..2^8-1)
// PORTS
//  clk             in   1   system clock, rising edge
//  rst             in   1   asynchronous reset, active-high
//  ExValid         in   1   upstream presents a valid instruction this cycle
//  ALUResult       in   DW  ALU output; memory address for loads/stores
//  StoreData       in   DW  rs2 value for stores
//  DmemREB         in   1   active-low read strobe (load)
//  DmemWEB         in   1   active-low write strobe (store)
//  Dmem1ALUOUT     in   1   1 = memory-class instruction
//  LoadStoremuxsel in   1   store data source: 1 = StoreData, 0 = all-zero word
//  Rd              in   5   destination register
//  RegWrite        in   1   instruction writes rd
//  Stall           out  1   upstream must hold its current inputs
//  MemReq          out  1   memory request valid
//  MemWe           out  1   1 = write, 0 = read
//  MemAddr         out  AW  word-aligned byte address
//  MemWData        out  DW  write data
//  MemAck          in   1   memory completes the request; MemRData is valid the same cycle for reads
//  MemRData        in   DW  read data
//  WbValid         out  1   writeback record valid; 1-cycle pulse
//  WbRd            out  5   writeback rd
//  WbData          out  DW  writeback data
//  WbRegWrite      out  1   write enable to register file
//  MemErr          out  1   1-cycle pulse: illegal, misaligned or timed-out access
// BEHAVIOUR
//  Reset (async, immediate)
//   - state=IDLE, timeout counter=0.
//   - Stall, MemReq, MemWe, MemAddr, MemWData, WbValid, WbRd, WbData, WbRegWrite, MemErr all 0.
//  States
//   - IDLE: instructions are accepted only here.
//   - BUSY: transaction open.
//   - Stall = (state==BUSY); decoded from registered state only, no combinational path from inputs.
//  IDLE, ExValid=0
//   - WbValid=0 next cycle.
//  IDLE, ExValid=1, REB=WEB=1 (ALU op)
//   - next edge: WbValid=1, WbData=ALUResult, WbRd=Rd, WbRegWrite=RegWrite. Latency 1.
//  IDLE, ExValid=1, exactly one strobe low, ALUResult[1:0]==0
//   - Latch Rd and RegWrite.
//   - MemAddr=ALUResult[AW-1:0], MemWe=~DmemWEB.
//   - MemWData = LoadStoremuxsel ? StoreData : 0.
//   - MemReq=1, counter=0; go BUSY next edge.
//  IDLE error cases
//   - Cause: REB=WEB=0 (illegal), or one strobe low with ALUResult[1:0]!=0 (misaligned).
//   - No bus access.
//   - Next edge: MemErr=1, WbValid=1, WbRegWrite=0, WbData=ALUResult.
//  BUSY
//   - MemReq, MemWe, MemAddr, MemWData held stable until MemAck.
//   - Counter increments each BUSY cycle without MemAck.
//  BUSY, MemAck=1
//   - Next edge: MemReq=0, state=IDLE, WbValid=1.
//   - Load: WbData=MemRData sampled this cycle, WbRegWrite=latched RegWrite.
//   - Store: WbData=MemAddr, WbRegWrite=0.
//   - Ack in the first BUSY cycle is legal; minimum load latency is 2 cycles from acceptance.
//  BUSY, counter==TIMEOUT-1 and MemAck=0
//   - Next edge: MemReq=0, IDLE, MemErr=1, WbValid=1, WbRegWrite=0.
//  Simultaneous events
//   - MemAck on the timeout cycle counts as success.
//   - MemAck while IDLE is ignored.
//   - ExValid while BUSY is ignored (upstream holds it; it is accepted in the first IDLE cycle).
//  Back-to-back
//   - The instruction held during BUSY is accepted on the cycle state returns to IDLE.
//   - No bubble beyond the memory wait.
//  Reset mid-BUSY
//   - Transaction is abandoned; MemReq drops asynchronously.
//   - A late MemAck after reset is ignored.
// TESTING
//  1. ALU op: ExValid=1, REB=WEB=1, ALUResult=32'h1234, Rd=5, RegWrite=1
//     -> next cycle WbValid=1, WbData=32'h1234, WbRd=5, Stall=0.
//  2. LW addr 32'h100, MemAck 3 cycles after MemReq rises, MemRData=32'hDEADBEEF
//     -> Stall=1 for 4 cycles, MemWe=0, WbData=32'hDEADBEEF, WbRegWrite=1.
//  3. SW addr 32'h104, StoreData=32'hA5A5A5A5, LoadStoremuxsel=1, ack in first BUSY cycle
//     -> MemWe=1, MemWData=32'hA5A5A5A5, WbRegWrite=0, Stall high 1 cycle.
//  4. LW addr 32'h102, then REB=WEB=0 on next instruction
//     -> MemReq never asserted, MemErr pulses twice, WbRegWrite=0 both.
//  5. LW with no MemAck, TIMEOUT=4
//     -> MemReq high 4 cycles, then MemErr=1, WbValid=1, WbRegWrite=0, IDLE.
//  6. Assert rst in the 2nd BUSY cycle, MemAck 1 cycle after release
//     -> all outputs 0 immediately, no WbValid, ack ignored.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage running a req/ack data-memory transaction
// with timeout and delivering a registered writeback record.
module mem_access_stage #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ExValid,
    input  logic [DW-1:0] ALUResult,
    input  logic [DW-1:0] StoreData,
    input  logic          DmemREB,
    input  logic          DmemWEB,
    input  logic          Dmem1ALUOUT,
    input  logic          LoadStoremuxsel,
    input  logic [4:0]    Rd,
    input  logic          RegWrite,
    output logic          Stall,
    output logic          MemReq,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWData,
    input  logic          MemAck,
    input  logic [DW-1:0] MemRData,
    output logic          WbValid,
    output logic [4:0]    WbRd,
    output logic [DW-1:0] WbData,
    output logic          WbRegWrite,
    output logic          MemErr
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t        r_state, w_state;
    logic [7:0]    r_cnt, w_cnt;
    logic          r_req, w_req, r_we, w_we;
    logic [AW-1:0] r_addr, w_addr;
    logic [DW-1:0] r_wdata, w_wdata, r_wb_data, w_wb_data;
    logic [4:0]    r_rd, w_rd, r_wb_rd, w_wb_rd;
    logic          r_rw, w_rw, r_wb_valid, w_wb_valid, r_wb_rw, w_wb_rw, r_err, w_err;
    logic          w_bad, w_done, w_unused;
    // Strobe decode (Dmem1ALUOUT is redundant with the strobes)
    assign w_unused = Dmem1ALUOUT;
    assign w_bad    = ~(DmemREB | DmemWEB) | (|ALUResult[1:0]);
    assign w_done   = MemAck | (r_cnt == 8'(TIMEOUT - 1));
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_req      = r_req;
        w_we       = r_we;
        w_addr     = r_addr;
        w_wdata    = r_wdata;
        w_rd       = r_rd;
        w_rw       = r_rw;
        w_wb_valid = 1'b0;
        w_wb_rd    = r_wb_rd;
        w_wb_data  = r_wb_data;
        w_wb_rw    = 1'b0;
        w_err      = 1'b0;
        if (r_state == IDLE) begin
            if (ExValid && DmemREB && DmemWEB) begin
                w_wb_valid = 1'b1;
                w_wb_rd    = Rd;
                w_wb_data  = ALUResult;
                w_wb_rw    = RegWrite;
            end else if (ExValid && w_bad) begin
                w_wb_valid = 1'b1;
                w_wb_rd    = Rd;
                w_wb_data  = ALUResult;
                w_err      = 1'b1;
            end else if (ExValid) begin
                w_rd    = Rd;
                w_rw    = RegWrite;
                w_addr  = ALUResult[AW-1:0];
                w_we    = ~DmemWEB;
                w_wdata = LoadStoremuxsel ? StoreData : '0;
                w_req   = 1'b1;
                w_cnt   = 8'd0;
                w_state = BUSY;
            end
        end else if (w_done) begin
            // An ack on the timeout cycle still counts as success
            w_req      = 1'b0;
            w_state    = IDLE;
            w_wb_valid = 1'b1;
            w_wb_rd    = r_rd;
            w_err      = ~MemAck;
            w_wb_rw    = MemAck & ~r_we & r_rw;
            w_wb_data  = (r_we | ~MemAck) ? DW'(r_addr) : MemRData;
        end else begin
            w_cnt = r_cnt + 8'd1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd       <= '0;
            r_rw       <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_wb_rw    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_req      <= w_req;
            r_we       <= w_we;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            r_rd       <= w_rd;
            r_rw       <= w_rw;
            r_wb_valid <= w_wb_valid;
            r_wb_rd    <= w_wb_rd;
            r_wb_data  <= w_wb_data;
            r_wb_rw    <= w_wb_rw;
            r_err      <= w_err;
        end
    end
    assign Stall      = (r_state == BUSY);
    assign MemReq     = r_req;
    assign MemWe      = r_we;
    assign MemAddr    = r_addr;
    assign MemWData   = r_wdata;
    assign WbValid    = r_wb_valid;
    assign WbRd       = r_wb_rd;
    assign WbData     = r_wb_data;
    assign WbRegWrite = r_wb_rw;
    assign MemErr     = r_err;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench; the issue task predicts each writeback
// record and its arrival cycle, a monitor pops and compares on every WbValid.
module tb_mem_access_stage;
    localparam int T = 4;
    logic        clk = 1'b0, rst = 1'b1;
    logic        ExValid = 0, DmemREB = 1, DmemWEB = 1, Dmem1ALUOUT = 0, LoadStoremuxsel = 0;
    logic [31:0] ALUResult = 0, StoreData = 0, MemRData = 0;
    logic [4:0]  Rd = 0;
    logic        RegWrite = 0, MemAck = 0;
    logic        Stall, MemReq, MemWe, WbValid, WbRegWrite, MemErr;
    logic [31:0] MemAddr, MemWData, WbData;
    logic [4:0]  WbRd;

    mem_access_stage #(.AW(32), .DW(32), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .ExValid(ExValid), .ALUResult(ALUResult), .StoreData(StoreData),
        .DmemREB(DmemREB), .DmemWEB(DmemWEB), .Dmem1ALUOUT(Dmem1ALUOUT),
        .LoadStoremuxsel(LoadStoremuxsel), .Rd(Rd), .RegWrite(RegWrite), .Stall(Stall),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemAck(MemAck), .MemRData(MemRData), .WbValid(WbValid), .WbRd(WbRd),
        .WbData(WbData), .WbRegWrite(WbRegWrite), .MemErr(MemErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk;
        logic        rw;
        logic        err;
    } exp_t;
    exp_t        q[$];
    int          cyc = 0, ntest = 0, nfail = 0;
    int          busy_start = 0, cur_d = 0;
    logic [31:0] cur_rdata = 0, exp_addr = 0, exp_wdata = 0;
    logic        exp_we = 0, hold = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        ntest++;
        if (a !== x) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", n, a, x, $time);
        end
    endtask

    // Reference: one instruction's writeback outcome from the strobes, alignment and memory behaviour
    task automatic issue(input logic v, input logic reb, input logic web, input logic [31:0] alu,
                         input logic [31:0] sd, input logic lsm, input logic [4:0] rd,
                         input logic rw, input int d, input logic [31:0] rdata);
        exp_t e;
        logic is_mem, is_st, bad;
        @(negedge clk);
        ExValid = v; DmemREB = reb; DmemWEB = web; ALUResult = alu; StoreData = sd;
        LoadStoremuxsel = lsm; Rd = rd; RegWrite = rw; Dmem1ALUOUT = !(reb && web);
        while (Stall) @(negedge clk);
        if (v) begin
            is_mem = reb ^ web;
            is_st  = !web;
            bad    = (!reb && !web) || (is_mem && alu[1:0] != 2'b00);
            e = '{cyc: cyc + 1, rd: rd, data: alu, chk: 1'b1, rw: rw, err: 1'b0};
            if (bad) begin
                e.rw = 1'b0; e.err = 1'b1;
            end else if (is_mem) begin
                busy_start = cyc + 1; cur_d = d; cur_rdata = rdata;
                exp_addr = alu; exp_we = is_st; exp_wdata = lsm ? sd : 32'h0;
                if (d < T) begin
                    e.cyc = cyc + 2 + d; e.data = is_st ? alu : rdata; e.rw = is_st ? 1'b0 : rw;
                end else begin
                    e.cyc = cyc + 1 + T; e.rw = 1'b0; e.err = 1'b1; e.chk = 1'b0;
                end
            end
            q.push_back(e);
        end
    endtask

    // Memory responder: acks after the chosen delay, random noise on MemAck while idle
    always @(negedge clk) begin
        if (!hold && !rst) begin
            if (Stall) begin
                MemAck   = ((cyc - busy_start) == cur_d);
                MemRData = MemAck ? cur_rdata : $urandom;
                chk("bus_req", {31'b0, MemReq}, 32'd1);
                chk("bus_addr", MemAddr, exp_addr);
                chk("bus_we", {31'b0, MemWe}, {31'b0, exp_we});
                chk("bus_wdata", MemWData, exp_wdata);
            end else begin
                MemAck   = $urandom_range(0, 1) == 1;
                MemRData = $urandom;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (WbValid) begin
                if (q.size() == 0) begin
                    chk("wb_unexpected", {31'b0, WbValid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("wb_cycle", cyc, e.cyc);
                    chk("wb_rd", {27'b0, WbRd}, {27'b0, e.rd});
                    if (e.chk) chk("wb_data", WbData, e.data);
                    chk("wb_regwrite", {31'b0, WbRegWrite}, {31'b0, e.rw});
                    chk("wb_err", {31'b0, MemErr}, {31'b0, e.err});
                end
            end else if (MemErr) begin
                chk("err_without_wb", {31'b0, MemErr}, 32'd0);
            end
        end
    end

    task automatic chk_zero(input string n);
        chk({n, "_stall"}, {31'b0, Stall}, 0);
        chk({n, "_memreq"}, {31'b0, MemReq}, 0);
        chk({n, "_memwe"}, {31'b0, MemWe}, 0);
        chk({n, "_memaddr"}, MemAddr, 0);
        chk({n, "_memwdata"}, MemWData, 0);
        chk({n, "_wbvalid"}, {31'b0, WbValid}, 0);
        chk({n, "_wbrd"}, {27'b0, WbRd}, 0);
        chk({n, "_wbdata"}, WbData, 0);
        chk({n, "_wbrw"}, {31'b0, WbRegWrite}, 0);
        chk({n, "_memerr"}, {31'b0, MemErr}, 0);
    endtask

    initial begin
        int k, d;
        logic [31:0] a;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        issue(1, 1, 1, 32'h1234, 0, 0, 5'd5, 1, 0, 0);
        issue(1, 0, 1, 32'h100, 0, 0, 5'd6, 1, 3, 32'hDEADBEEF);
        issue(1, 1, 0, 32'h104, 32'hA5A5A5A5, 1, 5'd7, 1, 0, 0);
        issue(1, 1, 0, 32'h108, 32'hFFFF0000, 0, 5'd8, 1, 1, 0);
        issue(1, 0, 1, 32'h102, 0, 0, 5'd9, 1, 0, 0);
        issue(1, 0, 0, 32'h200, 0, 0, 5'd10, 1, 0, 0);
        issue(1, 0, 1, 32'h300, 0, 0, 5'd11, 1, T, 0);
        issue(1, 0, 1, 32'h304, 0, 0, 5'd12, 1, T - 1, 32'h600DF00D);
        issue(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 120; i++) begin
            k = $urandom_range(0, 9);
            d = $urandom_range(0, T + 1);
            a = $urandom;
            if (k <= 1)      issue(1, 1, 1, a, $urandom, 1'($urandom), 5'($urandom), 1'($urandom), d, 0);
            else if (k <= 4) issue(1, 0, 1, a & ~32'h3, 0, 0, 5'($urandom), 1'($urandom), d, $urandom);
            else if (k <= 6) issue(1, 1, 0, a & ~32'h3, $urandom, 1'($urandom), 5'($urandom), 1'($urandom), d, 0);
            else if (k == 7) issue(1, 1'($urandom), 1'($urandom) | 1'b0, a | 32'($urandom_range(1, 3)), 0, 0, 5'($urandom), 1, d, 0);
            else if (k == 8) issue(1, 0, 0, a, $urandom, 1, 5'($urandom), 1, d, 0);
            else             issue(0, 1, 1, a, 0, 0, 0, 0, 0, 0);
        end
        issue(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        chk("drain", q.size(), 0);
        // Reset in the second BUSY cycle, then a stale ack that must be ignored
        @(negedge clk);
        while (Stall) @(negedge clk);
        hold = 1'b1; MemAck = 1'b0;
        ExValid = 1; DmemREB = 0; DmemWEB = 1; ALUResult = 32'h400; Rd = 5'd3; RegWrite = 1;
        @(negedge clk);
        ExValid = 0;
        chk("rst_busy", {31'b0, Stall}, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        MemAck = 1'b1; MemRData = 32'hBAD0BAD0;
        @(negedge clk);
        MemAck = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_stall", {31'b0, Stall}, 0);
        chk("post_rst_req", {31'b0, MemReq}, 0);
        chk("post_rst_q", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
